uart_rx_param: RTL

Parametrised next-generation UART receiver for the Hamming(7,4) link. Configurable frame width and oversampling ratio, 3-sample majority-vote bit decisions, and an input synchroniser. Adds framing/overrun error reporting and a valid/ready output handshake with a one-entry holding register. Sits between the rx pad and the Hamming decoder.

---
 rtl/uart_rx_param.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver: 2-flop rx synchroniser, 3-sample majority vote per bit,
// framing/overrun reporting and a one-entry valid/ready holding register.
// Optional even-parity bit and parity_err reporting when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_rx_param #(
   parameter int unsigned DATA_BITS  = 7,
   parameter int unsigned OVERSAMPLE = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid_out,
   input  logic                 ready_in,
   output logic [2:0]           state_out,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 parity_err
);

   localparam int unsigned MID = OVERSAMPLE / 2;
   localparam int unsigned CW  = $clog2(OVERSAMPLE);
   localparam int unsigned BW  = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        sample_cnt_q, sample_cnt_d;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [1:0]           smp_q, smp_d;
   logic                 rx_meta_q, rx_s_q;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
   logic                 par_bad_q, par_bad_d;
   logic                 parity_err_q, parity_err_d;
`endif

   logic [CW-1:0] tick_c;
   logic          decision_c;
   logic          at_mid1_c;
   logic          at_end_c;
   logic          stop_eval_c;

   // Index of the tick being processed on this ena pulse
   assign tick_c      = (sample_cnt_q == CW'(OVERSAMPLE - 1)) ? '0 : sample_cnt_q + CW'(1);
   assign decision_c  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
   assign at_mid1_c   = (tick_c == CW'(MID + 1));
   assign at_end_c    = (tick_c == CW'(OVERSAMPLE - 1));
   assign stop_eval_c = (state_q == S_STOP) && ena && at_mid1_c;

   // State register, datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         sample_cnt_q <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         smp_q        <= '0;
         rx_meta_q    <= 1'b1;
         rx_s_q       <= 1'b1;
         data_q       <= '0;
         valid_q      <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         sample_cnt_q <= sample_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         smp_q        <= smp_d;
         rx_meta_q    <= rx;
         rx_s_q       <= rx_meta_q;
         data_q       <= data_d;
         valid_q      <= valid_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   // Next-state and bit-level datapath
   always_comb begin
      state_d      = state_q;
      sample_cnt_d = sample_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      smp_d        = smp_q;
`ifdef UART_RX_PARITY_EN
      par_bad_d    = par_bad_q;
`endif
      if (ena && state_q != S_IDLE) begin
         sample_cnt_d = tick_c;
         if (tick_c == CW'(MID - 1)) smp_d[0] = rx_s_q;
         if (tick_c == CW'(MID))     smp_d[1] = rx_s_q;
      end
      unique case (state_q)
         S_IDLE: begin
            if (ena && !rx_s_q) begin
               state_d      = S_START;
               sample_cnt_d = '0;
            end
         end
         S_START: begin
            if (ena && at_mid1_c && decision_c) begin
               state_d = S_IDLE;
            end else if (ena && at_end_c) begin
               state_d   = S_DATA;
               bit_cnt_d = '0;
            end
         end
         S_DATA: begin
            if (ena) begin
               if (at_mid1_c) shift_d = {decision_c, shift_q[DATA_BITS-1:1]};
               if (at_end_c) begin
                  if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                     state_d = S_PARITY;
`else
                     state_d = S_STOP;
`endif
                  end else begin
                     bit_cnt_d = bit_cnt_q + BW'(1);
                  end
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (ena) begin
               if (at_mid1_c) par_bad_d = decision_c ^ (^shift_q);
               if (at_end_c)  state_d   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (ena && at_mid1_c) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Delivery, holding-register handshake and error pulses
   always_comb begin
      data_d      = data_q;
      valid_d     = valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d = 1'b0;
`endif
      if (valid_q && ready_in) valid_d = 1'b0;
      if (stop_eval_c) begin
         if (!decision_c) begin
            frame_err_d = 1'b1;
         end
`ifdef UART_RX_PARITY_EN
         else if (par_bad_q) begin
            parity_err_d = 1'b1;
         end
`endif
         else if (valid_q && !ready_in) begin
            overrun_d = 1'b1;
         end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end
      end
   end

   assign data_out    = data_q;
   assign valid_out   = valid_q;
   assign state_out   = state_q;
   assign frame_err   = frame_err_q;
   assign overrun_err = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err  = parity_err_q;
`else
   assign parity_err  = 1'b0;
`endif

endmodule
